// File: rtl/regfile_rename.sv
// Architectural register file with rename/busy table and r0 console.
// Ports: commit_* (4 lanes), disp_* (4 lanes), src_* (8 slots), char_* (4 lanes); optional BYPASS_EN.
module regfile_rename #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            commit_wen_flat,
  input  logic [15:0]           commit_targets_flat,
  input  logic [4*DATA_W-1:0]   commit_data_flat,
  input  logic [4*TAG_W-1:0]    commit_writers_flat,
  input  logic [3:0]            disp_valid_flat,
  input  logic [15:0]           disp_dests_flat,
  input  logic [4*TAG_W-1:0]    disp_tags_flat,
  input  logic [31:0]           src_regs_flat,
  input  logic                  flush,
  output logic [7:0]            src_ready_flat,
  output logic [8*DATA_W-1:0]   src_values_flat,
  output logic [8*TAG_W-1:0]    src_tags_flat,
  output logic [3:0]            char_valid_flat,
  output logic [31:0]           char_data_flat
);

  localparam int NL = 4;
  localparam int NR = 16;
  localparam int NS = 8;

  logic              c_wen  [NL];
  logic [3:0]        c_tgt  [NL];
  logic [DATA_W-1:0] c_data [NL];
  logic [TAG_W-1:0]  c_wr   [NL];
  logic              d_val  [NL];
  logic [3:0]        d_dest [NL];
  logic [TAG_W-1:0]  d_tag  [NL];
  logic [3:0]        s_reg  [NS];

  logic [DATA_W-1:0] value_q [NR];
  logic [NR-1:0]     busy_q;
  logic [TAG_W-1:0]  tag_q   [NR];
  logic              cv_q    [NL];
  logic [7:0]        cd_q    [NL];

  // Lane 0 always lives in the most significant slice.
  for (genvar i = 0; i < NL; i++) begin : g_lane
    assign c_wen[i]  = commit_wen_flat[NL-1-i];
    assign c_tgt[i]  = commit_targets_flat[4*(NL-i)-1 -: 4];
    assign c_data[i] = commit_data_flat[DATA_W*(NL-i)-1 -: DATA_W];
    assign c_wr[i]   = commit_writers_flat[TAG_W*(NL-i)-1 -: TAG_W];
    assign d_val[i]  = disp_valid_flat[NL-1-i];
    assign d_dest[i] = disp_dests_flat[4*(NL-i)-1 -: 4];
    assign d_tag[i]  = disp_tags_flat[TAG_W*(NL-i)-1 -: TAG_W];
    assign char_valid_flat[NL-1-i]       = cv_q[i];
    assign char_data_flat[8*(NL-i)-1 -: 8] = cd_q[i];
  end

  for (genvar s = 0; s < NS; s++) begin : g_slot
    localparam int K = s / 2;
    logic              rdy;
    logic [DATA_W-1:0] val;
    logic [TAG_W-1:0]  tg;
    logic              dep;
`ifdef BYPASS_EN
    logic              hit;
    logic [DATA_W-1:0] bv;
`endif

    assign s_reg[s] = src_regs_flat[4*(NS-s)-1 -: 4];

    always_comb begin
      rdy = 1'b0;
      val = '0;
      tg  = '0;
      dep = 1'b0;
`ifdef BYPASS_EN
      hit = 1'b0;
      bv  = '0;
`endif
      if (s_reg[s] == 4'd0) begin
        rdy = 1'b1;
      end else begin
        // Ascending scan: the youngest older lane ends up winning.
        for (int j = 0; j < NL; j++) begin
          if (j < K && d_val[j] && d_dest[j] == s_reg[s]) begin
            dep = 1'b1;
            tg  = d_tag[j];
          end
        end
        if (!dep) begin
          if (busy_q[s_reg[s]]) begin
            tg = tag_q[s_reg[s]];
`ifdef BYPASS_EN
            for (int i = 0; i < NL; i++) begin
              if (c_wen[i] && c_tgt[i] == s_reg[s] &&
                  c_wr[i] == tag_q[s_reg[s]]) begin
                hit = 1'b1;
                bv  = c_data[i];
              end
            end
            if (hit) begin
              rdy = 1'b1;
              val = bv;
              tg  = '0;
            end
`endif
          end else begin
            rdy = 1'b1;
            val = value_q[s_reg[s]];
          end
        end
      end
    end

    assign src_ready_flat[NS-1-s]                  = rdy;
    assign src_values_flat[DATA_W*(NS-s)-1 -: DATA_W] = val;
    assign src_tags_flat[TAG_W*(NS-s)-1 -: TAG_W]     = tg;
  end

  // Later loop iterations override earlier ones, so the highest
  // lane wins; flush and dispatch come last to take busy/tag priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int r = 0; r < NR; r++) begin
        value_q[r] <= '0;
        tag_q[r]   <= '0;
      end
      for (int i = 0; i < NL; i++) begin
        cv_q[i] <= 1'b0;
        cd_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NL; i++) begin
        cv_q[i] <= c_wen[i] && c_tgt[i] == 4'd0;
        if (c_wen[i] && c_tgt[i] == 4'd0) begin
          cd_q[i] <= c_data[i][7:0];
        end
      end
      for (int i = 0; i < NL; i++) begin
        if (c_wen[i] && c_tgt[i] != 4'd0) begin
          value_q[c_tgt[i]] <= c_data[i];
          busy_q[c_tgt[i]]  <= (tag_q[c_tgt[i]] == c_wr[i]) ?
                               1'b0 : busy_q[c_tgt[i]];
        end
      end
      if (flush) begin
        busy_q <= '0;
      end else begin
        for (int i = 0; i < NL; i++) begin
          if (d_val[i] && d_dest[i] != 4'd0) begin
            busy_q[d_dest[i]] <= 1'b1;
            tag_q[d_dest[i]]  <= d_tag[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_rename.sv
// Scoreboard bench for regfile_rename: directed test-plan cycles then random traffic.
// Expectations come from an array-based model of the register/rename rules.
module tb_regfile_rename;
  localparam int DW = 16;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cw   [4];
  logic [3:0]    ct   [4];
  logic [DW-1:0] cdat [4];
  logic [TW-1:0] cwr  [4];
  logic          dv   [4];
  logic [3:0]    dd   [4];
  logic [TW-1:0] dt   [4];
  logic [3:0]    sr   [8];
  logic          fl;

  logic [3:0]      wen_f, dv_f;
  logic [15:0]     tgt_f, dd_f;
  logic [4*DW-1:0] dat_f;
  logic [4*TW-1:0] wr_f, dt_f;
  logic [31:0]     src_f;
  logic [7:0]      rdy_f;
  logic [8*DW-1:0] val_f;
  logic [8*TW-1:0] tag_f;
  logic [3:0]      cv_f;
  logic [31:0]     cd_f;

  always_comb begin
    wen_f = '0; dv_f = '0; tgt_f = '0; dd_f = '0;
    dat_f = '0; wr_f = '0; dt_f = '0; src_f = '0;
    for (int i = 0; i < 4; i++) begin
      wen_f[3-i]          = cw[i];
      tgt_f[4*(3-i) +: 4] = ct[i];
      dat_f[DW*(3-i) +: DW] = cdat[i];
      wr_f[TW*(3-i) +: TW]  = cwr[i];
      dv_f[3-i]           = dv[i];
      dd_f[4*(3-i) +: 4]  = dd[i];
      dt_f[TW*(3-i) +: TW]  = dt[i];
    end
    for (int s = 0; s < 8; s++) src_f[4*(7-s) +: 4] = sr[s];
  end

  regfile_rename #(.DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .commit_wen_flat(wen_f), .commit_targets_flat(tgt_f),
    .commit_data_flat(dat_f), .commit_writers_flat(wr_f),
    .disp_valid_flat(dv_f), .disp_dests_flat(dd_f),
    .disp_tags_flat(dt_f), .src_regs_flat(src_f), .flush(fl),
    .src_ready_flat(rdy_f), .src_values_flat(val_f),
    .src_tags_flat(tag_f), .char_valid_flat(cv_f),
    .char_data_flat(cd_f)
  );

  // Reference state
  logic [DW-1:0] mval  [16];
  logic          mbusy [16];
  logic [TW-1:0] mtag  [16];
  logic          mcv   [4];
  logic [7:0]    mcd   [4];

  typedef struct {
    logic [7:0]    rdy;
    logic [8*DW-1:0] val;
    logic [8*TW-1:0] tag;
    logic [3:0]    cv;
    logic [31:0]   cd;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int n_cmp = 0;
  int n_err = 0;

  task automatic model_reset();
    for (int r = 0; r < 16; r++) begin
      mval[r] = '0; mbusy[r] = 1'b0; mtag[r] = '0;
    end
    for (int i = 0; i < 4; i++) begin mcv[i] = 1'b0; mcd[i] = '0; end
  endtask

  // Apply one clock edge to the model using the inputs held at that edge.
  task automatic model_edge();
    int ci, di;
    logic clr;
    for (int i = 0; i < 4; i++) begin
      mcv[i] = cw[i] && ct[i] == 4'd0;
      if (mcv[i]) mcd[i] = cdat[i][7:0];
    end
    for (int r = 1; r < 16; r++) begin
      ci = -1; di = -1; clr = 1'b0;
      for (int i = 3; i >= 0; i--)
        if (ci < 0 && cw[i] && ct[i] == 4'(r)) ci = i;
      for (int i = 3; i >= 0; i--)
        if (di < 0 && dv[i] && dd[i] == 4'(r)) di = i;
      if (ci >= 0) begin
        clr = (mtag[r] == cwr[ci]);
        mval[r] = cdat[ci];
      end
      if (fl) mbusy[r] = 1'b0;
      else if (di >= 0) begin
        mbusy[r] = 1'b1;
        mtag[r] = dt[di];
      end else if (clr) mbusy[r] = 1'b0;
    end
  endtask

  task automatic lookup(input int s, output logic rdy,
                        output logic [DW-1:0] v, output logic [TW-1:0] t);
    int r;
    r = int'(sr[s]);
    rdy = 1'b1; v = '0; t = '0;
    if (r == 0) return;
    for (int j = s / 2 - 1; j >= 0; j--) begin
      if (dv[j] && dd[j] == 4'(r)) begin
        rdy = 1'b0; t = dt[j];
        return;
      end
    end
    if (mbusy[r]) begin
`ifdef BYPASS_EN
      for (int i = 3; i >= 0; i--) begin
        if (cw[i] && ct[i] == 4'(r) && cwr[i] == mtag[r]) begin
          v = cdat[i];
          return;
        end
      end
`endif
      rdy = 1'b0; t = mtag[r];
      return;
    end
    v = mval[r];
  endtask

  task automatic clr_in();
    fl = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cw[i] = 1'b0; ct[i] = '0; cdat[i] = '0; cwr[i] = '0;
      dv[i] = 1'b0; dd[i] = '0; dt[i] = '0;
    end
    for (int s = 0; s < 8; s++) sr[s] = '0;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
    if (rst_n) model_edge();
    clr_in();
  endtask

  task automatic chk();
    exp_t x;
    logic r1;
    logic [DW-1:0] v1;
    logic [TW-1:0] t1;
    if (!rst_n) model_reset();
    for (int s = 0; s < 8; s++) begin
      lookup(s, r1, v1, t1);
      x.rdy[7-s] = r1;
      x.val[DW*(7-s) +: DW] = v1;
      x.tag[TW*(7-s) +: TW] = t1;
    end
    for (int i = 0; i < 4; i++) begin
      x.cv[3-i] = mcv[i];
      x.cd[8*(3-i) +: 8] = mcd[i];
    end
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      logic [31:0] m;
      e = q.pop_front();
      m = {{8{e.cv[3]}}, {8{e.cv[2]}}, {8{e.cv[1]}}, {8{e.cv[0]}}};
      n_cmp++;
      if (rdy_f !== e.rdy) begin
        n_err++;
        $display("FAIL src_ready t=%0t got %h want %h", $time, rdy_f, e.rdy);
      end
      n_cmp++;
      if (val_f !== e.val) begin
        n_err++;
        $display("FAIL src_values t=%0t got %h want %h", $time, val_f, e.val);
      end
      n_cmp++;
      if (tag_f !== e.tag) begin
        n_err++;
        $display("FAIL src_tags t=%0t got %h want %h", $time, tag_f, e.tag);
      end
      n_cmp++;
      if (cv_f !== e.cv) begin
        n_err++;
        $display("FAIL char_valid t=%0t got %b want %b", $time, cv_f, e.cv);
      end
      n_cmp++;
      if ((cd_f & m) !== (e.cd & m)) begin
        n_err++;
        $display("FAIL char_data t=%0t got %h want %h (mask %h)",
                 $time, cd_f, e.cd, m);
      end
    end
  end

  initial begin
    clr_in();
    model_reset();
    for (int c = 0; c < 3; c++) begin
      edge_step();
      for (int s = 0; s < 8; s++) sr[s] = 4'($urandom);
      chk();
    end
    edge_step();
    rst_n = 1'b1;
    chk();

    // Rename then commit
    edge_step(); dv[0] = 1; dd[0] = 3; dt[0] = 7; chk();
    edge_step(); sr[0] = 3; sr[5] = 3;
    cw[1] = 1; ct[1] = 3; cwr[1] = 7; cdat[1] = 16'h1234; chk();
    edge_step(); sr[0] = 3; sr[7] = 3; chk();

    // Stale writer
    edge_step(); dv[2] = 1; dd[2] = 4; dt[2] = 2; chk();
    edge_step(); dv[1] = 1; dd[1] = 4; dt[1] = 9; chk();
    edge_step(); cw[0] = 1; ct[0] = 4; cwr[0] = 2; cdat[0] = 16'h0055;
    sr[1] = 4; chk();
    edge_step(); sr[1] = 4; sr[3] = 4; chk();

    // Intra-group dependence
    edge_step(); dv[0] = 1; dd[0] = 6; dt[0] = 1;
    dv[2] = 1; dd[2] = 6; dt[2] = 3; sr[6] = 6; sr[2] = 6; chk();
    edge_step(); sr[0] = 6; chk();

    // Console
    edge_step(); cw[0] = 1; ct[0] = 0; cdat[0] = 16'h0048;
    cw[1] = 1; ct[1] = 0; cdat[1] = 16'h0069; chk();
    edge_step(); chk();
    edge_step(); chk();

    // Flush
    edge_step(); dv[3] = 1; dd[3] = 2; dt[3] = 5; chk();
    edge_step(); fl = 1; sr[4] = 2; dv[0] = 1; dd[0] = 9; dt[0] = 1; chk();
    edge_step(); sr[4] = 2; sr[5] = 9; chk();

    // Same-cycle commit to a busy reg (forwarded only with BYPASS_EN)
    edge_step(); dv[1] = 1; dd[1] = 8; dt[1] = 4; chk();
    edge_step(); cw[2] = 1; ct[2] = 8; cwr[2] = 4; cdat[2] = 16'hBEEF;
    sr[0] = 8; chk();
    edge_step(); sr[0] = 8; chk();

    // Asynchronous reset with r5 busy
    edge_step(); dv[0] = 1; dd[0] = 5; dt[0] = 3; chk();
    edge_step(); cw[0] = 1; ct[0] = 0; cdat[0] = 16'h0041; chk();
    edge_step(); rst_n = 1'b0; sr[0] = 5; sr[3] = 5; sr[6] = 3; chk();
    edge_step(); sr[0] = 5; chk();
    edge_step(); rst_n = 1'b1; sr[0] = 5; chk();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      edge_step();
      for (int i = 0; i < 4; i++) begin
        cw[i]   = ($urandom_range(0, 1) == 1);
        ct[i]   = 4'($urandom_range(0, 7));
        cdat[i] = DW'($urandom);
        cwr[i]  = ($urandom_range(0, 2) != 0) ? mtag[ct[i]] : TW'($urandom);
        dv[i]   = ($urandom_range(0, 2) == 0);
        dd[i]   = 4'($urandom_range(0, 7));
        dt[i]   = TW'($urandom);
      end
      for (int s = 0; s < 8; s++) sr[s] = 4'($urandom_range(0, 8));
      fl = ($urandom_range(0, 15) == 0);
      chk();
    end

    edge_step();
    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
